// File: rtl/reg_write_queue_pkg.sv
// Shared widths, entry type and count-width constant for the writeback queue slice.
package mips16_wb_pkg;

   localparam int REG_ADDR_W = 3;
   localparam int REG_DATA_W = 16;
   localparam int WB_DEPTH   = 4;
   localparam int WB_CNT_W   = $clog2(WB_DEPTH) + 1;

   // One pending register write.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] dest;
      logic [REG_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/reg_write_queue_if.sv
// Producer handshake plus register-file write port seen by the writeback queue.
interface reg_write_queue_if
   import mips16_wb_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
);

   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_dest;
   logic [DATA_W-1:0] in_data;
   logic              wr_grant;
   logic              reg_write_en;
   logic [ADDR_W-1:0] reg_write_dest;
   logic [DATA_W-1:0] reg_write_data;

   // Pipeline / register-file side.
   modport master (
      output in_valid, in_dest, in_data, wr_grant,
      input  in_ready, reg_write_en, reg_write_dest, reg_write_data
   );

   // Queue side.
   modport slave (
      input  in_valid, in_dest, in_data, wr_grant,
      output in_ready, reg_write_en, reg_write_dest, reg_write_data
   );

endinterface

// File: rtl/reg_write_queue_bypass.sv
// Combinational youngest-match search over the occupied part of the circular buffer.
module reg_write_bypass
   import mips16_wb_pkg::*;
#(
   parameter int DEPTH  = WB_DEPTH,
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic [DEPTH-1:0][ADDR_W-1:0] dests,
   input  logic [DEPTH-1:0][DATA_W-1:0] datas,
   input  logic [$clog2(DEPTH)-1:0]     head,
   input  logic [$clog2(DEPTH):0]       count,
   input  logic [ADDR_W-1:0]            rd_addr,
   output logic                         hit,
   output logic [DATA_W-1:0]            data
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] idx;

   // Walk from oldest to youngest so a later (younger) match overrides an earlier one;
   // r0 never hits because writes to it are never stored.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PTR_W'(k);
         if ((CNT_W'(k) < count) && (rd_addr != '0) && (dests[idx] == rd_addr)) begin
            hit  = 1'b1;
            data = datas[idx];
         end
      end
   end

endmodule

// File: rtl/reg_write_queue.sv
// In-order writeback queue in front of the register file write port, with two bypass lookups.
module reg_write_queue
   import mips16_wb_pkg::*;
#(
   parameter int DEPTH  = WB_DEPTH,
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   reg_write_queue_if.slave         bus,
   input  logic [ADDR_W-1:0]        rd_addr_1,
   input  logic [ADDR_W-1:0]        rd_addr_2,
   output logic                     byp_hit_1,
   output logic                     byp_hit_2,
   output logic [DATA_W-1:0]        byp_data_1,
   output logic [DATA_W-1:0]        byp_data_2,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DEPTH-1:0][ADDR_W-1:0] dest_mem;
   logic [DEPTH-1:0][DATA_W-1:0] data_mem;
   logic [PTR_W-1:0]             rd_ptr;
   logic [PTR_W-1:0]             wr_ptr;
   logic                         push_fire;
   logic                         store;
   logic                         pop;

   // Full/empty come from count only, so in_ready has no path from in_valid or wr_grant.
   assign empty        = (count == '0);
   assign bus.in_ready = (count < CNT_W'(DEPTH));

   // A handshake to r0 completes but is dropped; only real destinations occupy a slot.
   assign push_fire = bus.in_valid && bus.in_ready;
   assign store     = push_fire && (bus.in_dest != '0);
   assign pop       = !empty && bus.wr_grant;

   // Head entry drives the write port directly; zeros while nothing is pending.
   assign bus.reg_write_en   = pop;
   assign bus.reg_write_dest = empty ? '0 : dest_mem[rd_ptr];
   assign bus.reg_write_data = empty ? '0 : data_mem[rd_ptr];

   // Storage, pointers and occupancy; reset discards everything pending at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dest_mem <= '0;
         data_mem <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         if (store) begin
            dest_mem[wr_ptr] <= bus.in_dest;
            data_mem[wr_ptr] <= bus.in_data;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({store, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   reg_write_bypass #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_bypass_1 (
      .dests   (dest_mem),
      .datas   (data_mem),
      .head    (rd_ptr),
      .count   (count),
      .rd_addr (rd_addr_1),
      .hit     (byp_hit_1),
      .data    (byp_data_1)
   );

   reg_write_bypass #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_bypass_2 (
      .dests   (dest_mem),
      .datas   (data_mem),
      .head    (rd_ptr),
      .count   (count),
      .rd_addr (rd_addr_2),
      .hit     (byp_hit_2),
      .data    (byp_data_2)
   );

endmodule
